fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 33 +++
 rtl/fetch_sequencer_sat_counter.sv | 22 ++
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Purpose: shared encodings for the IF stage (PC mux select, fetch FSM states).
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

  // PC mux select, shared with the IF-stage PC mux.
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;  // PC+4
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;  // branch target
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;  // jump target
  localparam logic [1:0] PC_SRC_EXC    = 2'b11;  // exception vector

  // Fetch FSM state encodings.
  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_MISS  = 2'b01;
  localparam logic [1:0] ST_REDIR = 2'b10;

  // Redirect winner: exception > branch > jump; PC_SRC_SEQ when none.
  function automatic logic [1:0] redirect_sel(input logic exc, input logic br, input logic jmp);
    if (exc)      return PC_SRC_EXC;
    else if (br)  return PC_SRC_BRANCH;
    else if (jmp) return PC_SRC_JUMP;
    else          return PC_SRC_SEQ;
  endfunction

  // Fold a branch/jump seen during a refill into the pending target.
  // A branch overwrites anything; a jump never overwrites a pending branch.
  function automatic logic [1:0] merge_pending(input logic [1:0] cur, input logic br, input logic jmp);
    if (br)                               return PC_SRC_BRANCH;
    else if (jmp && cur != PC_SRC_BRANCH) return PC_SRC_JUMP;
    else                                  return cur;
  endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Purpose: saturating up-counter (sticks at all-ones).
// Latency: count reflects an inc one cycle later.
// Backpressure: none; inc at saturation is dropped.
// Ports: clk, reset (async, active-high), inc, count[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Purpose: IF-stage fetch sequencer: PC select, IF/ID control, instruction refill handshake.
// Latency: all outputs combinational from state and current inputs (0 cycles).
// Backpressure: id_stall freezes PC and IF/ID; refill_req held until ack, exception or timeout.
// Ports: clk, reset; in: imem_hit, refill_ack, branch_taken, jump, exception, id_stall;
//        out: pcWrite, pcSrc[1:0], IF_flush, p1_pipeline_regWrite, refill_req, miss_count, fault.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int REFILL_TIMEOUT = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_hit,
  input  logic             refill_ack,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             exception,
  input  logic             id_stall,
  output logic             pcWrite,
  output logic [1:0]       pcSrc,
  output logic             IF_flush,
  output logic             p1_pipeline_regWrite,
  output logic             refill_req,
  output logic [CNT_W-1:0] miss_count,
  output logic             fault
);

  localparam int WAIT_W = $clog2(REFILL_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(REFILL_TIMEOUT);

  logic [1:0]        state, state_nxt;
  logic [1:0]        pend, pend_nxt;      // pending redirect target, PC_SRC_SEQ = none
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;  // completed MISS cycles of the current refill
  logic              miss_inc;
  logic [1:0]        run_sel;
  logic [1:0]        pend_merge;

  assign run_sel    = redirect_sel(exception, branch_taken, jump);
  assign pend_merge = merge_pending(pend, branch_taken, jump);

  always_comb begin
    pcWrite              = 1'b0;
    pcSrc                = PC_SRC_SEQ;
    IF_flush             = 1'b0;
    p1_pipeline_regWrite = 1'b0;
    refill_req           = 1'b0;
    fault                = 1'b0;
    miss_inc             = 1'b0;
    state_nxt            = state;
    pend_nxt             = pend;
    wait_nxt             = wait_cnt;

    case (state)
      ST_RUN: begin
        wait_nxt = '0;
        if (run_sel != PC_SRC_SEQ) begin
          pcWrite              = 1'b1;
          pcSrc                = run_sel;
          IF_flush             = 1'b1;
          p1_pipeline_regWrite = 1'b1;
        end else if (id_stall) begin
          // hold PC and IF/ID
        end else if (imem_hit) begin
          pcWrite              = 1'b1;
          p1_pipeline_regWrite = 1'b1;
        end else begin
          // bubble into ID while the line is refilled
          IF_flush             = 1'b1;
          p1_pipeline_regWrite = 1'b1;
          miss_inc             = 1'b1;
          state_nxt            = ST_MISS;
        end
      end

      ST_MISS: begin
        IF_flush             = 1'b1;
        p1_pipeline_regWrite = 1'b1;
        if (exception || (wait_cnt >= TIMEOUT_V)) begin
          // abort: request drops this cycle, pending work is discarded
          fault     = !exception;
          pcWrite   = 1'b1;
          pcSrc     = PC_SRC_EXC;
          pend_nxt  = PC_SRC_SEQ;
          wait_nxt  = '0;
          state_nxt = ST_RUN;
        end else begin
          refill_req = 1'b1;
          wait_nxt   = wait_cnt + WAIT_W'(1);
          pend_nxt   = pend_merge;
          if (refill_ack) begin
            // a redirect seen in the ack cycle itself still counts as pending
            wait_nxt  = '0;
            state_nxt = (pend_merge != PC_SRC_SEQ) ? ST_REDIR : ST_RUN;
          end
        end
      end

      ST_REDIR: begin
        pcWrite              = 1'b1;
        pcSrc                = exception ? PC_SRC_EXC : pend;
        IF_flush             = 1'b1;
        p1_pipeline_regWrite = 1'b1;
        pend_nxt             = PC_SRC_SEQ;
        state_nxt            = ST_RUN;
      end

      default: begin
        pend_nxt  = PC_SRC_SEQ;
        wait_nxt  = '0;
        state_nxt = ST_RUN;
      end
    endcase

    // Outputs are combinational, so reset must mask them directly.
    if (reset) begin
      pcWrite              = 1'b0;
      pcSrc                = PC_SRC_SEQ;
      IF_flush             = 1'b0;
      p1_pipeline_regWrite = 1'b0;
      refill_req           = 1'b0;
      fault                = 1'b0;
      miss_inc             = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      pend     <= PC_SRC_SEQ;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule
